// File: rtl/hedios_uart_pkg.sv
// Shared definitions for the Hedios UART receive and transmit paths.
package hedios_uart_pkg;

  // Payload bits per 8N1 character.
  localparam int unsigned UART_DATA_BITS = 8;

  // Receiver line-state sequence; the transmitter reuses the same names.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

  // Clocks per bit, CLK_RATE/BAUD_RATE rounded to nearest.
  function automatic int unsigned cpb(input int unsigned clk_rate,
                                      input int unsigned baud_rate);
    return (clk_rate + baud_rate / 2) / baud_rate;
  endfunction

endpackage

// File: rtl/hedios_sync2.sv
// Two-flop synchroniser for a single asynchronous bit, with a selectable reset level.
module hedios_sync2 #(
  parameter logic ResetVal = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Both stages reset to the idle level so the consumer sees no spurious edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/hedios_uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a down-counting baud timer, byte handed
// to the consumer over valid/ready, framing errors and overruns as one-cycle pulses.
module hedios_uart_rx
  import hedios_uart_pkg::*;
#(
  parameter int unsigned CLK_RATE  = 100_000_000,
  parameter int unsigned BAUD_RATE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_line,
  output logic [7:0] data,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CPB  = cpb(CLK_RATE, BAUD_RATE);
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CntW = $clog2(CPB);
  localparam int unsigned IdxW = $clog2(UART_DATA_BITS);

  localparam logic [CntW-1:0] HalfLoad = CntW'(HALF - 1);
  localparam logic [CntW-1:0] BitLoad  = CntW'(CPB - 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(UART_DATA_BITS - 1);

  // Below four clocks per bit the half-bit offset and reload values degenerate.
  if (CPB < 4) begin : g_cpb_too_small
    $error("hedios_uart_rx: CLK_RATE/BAUD_RATE yields fewer than 4 clocks per bit");
  end

  logic                      rxs;
  rx_state_t                 state_q;
  logic [CntW-1:0]           cnt_q;
  logic [IdxW-1:0]           idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      frame_err_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      overrun_q;

  logic                      cnt_zero;
  logic [CntW-1:0]           cnt_dec;
  logic                      byte_done;

  hedios_sync2 #(
    .ResetVal (1'b1)
  ) u_rx_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .d_i    (rx_line),
    .q_o    (rxs)
  );

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - CntW'(1);

  // A byte is complete when the stop bit samples high.
  assign byte_done = (state_q == STOP) && cnt_zero && rxs;

  // Receive sequencer: start detection, mid-bit sampling, stop check, break absorption.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            cnt_q   <= HalfLoad;
            state_q <= START;
          end
        end

        START: begin
          if (cnt_zero) begin
            if (!rxs) begin
              cnt_q   <= BitLoad;
              idx_q   <= '0;
              state_q <= DATA;
            end else begin
              // Glitch shorter than half a bit: drop it silently.
              state_q <= IDLE;
            end
          end else begin
            cnt_q <= cnt_dec;
          end
        end

        DATA: begin
          if (cnt_zero) begin
            shift_q <= {rxs, shift_q[UART_DATA_BITS-1:1]};
            cnt_q   <= BitLoad;
            if (idx_q == LastIdx) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + IdxW'(1);
            end
          end else begin
            cnt_q <= cnt_dec;
          end
        end

        STOP: begin
          if (cnt_zero) begin
            if (rxs) begin
              state_q <= IDLE;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_dec;
          end
        end

        WAIT_IDLE: begin
          // Hold off until the line returns high so a break is not read as data.
          if (rxs) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake; a full register with no
  // acceptance in the completion cycle keeps the old byte and flags an overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (byte_done) begin
        if (!valid_q || data_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && data_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_hedios_uart_rx.sv
// Bench for hedios_uart_rx: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a timeline model of the receiver.
module tb_hedios_uart_rx;

  localparam int CPB  = 100;
  localparam int HALF = 50;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_line;
  logic [7:0] data;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  hedios_uart_rx #(
    .CLK_RATE  (100_000_000),
    .BAUD_RATE (1_000_000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_line    (rx_line),
    .data       (data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model. A frame is anchored at the edge t0 where the synchronised
  // line (rx_line two edges earlier) is first seen low while idle; sample j is
  // taken at t0 + HALF + j*CPB (j=0 start, 1..8 data LSB first, 9 stop).
  // ---------------------------------------------------------------------------
  bit         m_live;
  logic       m_d1, m_d2, m_rxs;
  longint     m_cyc, m_t0, m_rel;
  int         m_j;
  bit         m_active, m_wait, m_done;
  logic [7:0] m_byte;
  logic       exp_valid, exp_fe, exp_ovr, exp_busy;
  logic [7:0] exp_data;

  always @(posedge clk) begin
    m_cyc = m_cyc + 1;
    if (!rst_n) begin
      m_live    = 1'b1;
      m_d1      = 1'b1;
      m_d2      = 1'b1;
      m_active  = 1'b0;
      m_wait    = 1'b0;
      m_byte    = 8'h00;
      exp_valid = 1'b0;
      exp_data  = 8'h00;
      exp_fe    = 1'b0;
      exp_ovr   = 1'b0;
    end else begin
      m_rxs   = m_d2;
      m_done  = 1'b0;
      exp_fe  = 1'b0;
      exp_ovr = 1'b0;
      if (m_wait) begin
        if (m_rxs) m_wait = 1'b0;
      end else if (!m_active) begin
        if (!m_rxs) begin
          m_active = 1'b1;
          m_t0     = m_cyc;
        end
      end else begin
        m_rel = m_cyc - m_t0 - HALF;
        if (m_rel >= 0 && (m_rel % CPB) == 0) begin
          m_j = int'(m_rel / CPB);
          if (m_j == 0) begin
            m_byte = 8'h00;
            if (m_rxs) m_active = 1'b0;
          end else if (m_j <= 8) begin
            m_byte = m_byte | (8'(m_rxs) << (m_j - 1));
          end else begin
            m_active = 1'b0;
            if (m_rxs) m_done = 1'b1;
            else begin
              exp_fe = 1'b1;
              m_wait = 1'b1;
            end
          end
        end
      end
      if (m_done) begin
        if (!exp_valid || data_ready) begin
          exp_data  = m_byte;
          exp_valid = 1'b1;
        end else begin
          exp_ovr = 1'b1;
        end
      end else if (exp_valid && data_ready) begin
        exp_valid = 1'b0;
      end
      m_d2 = m_d1;
      m_d1 = rx_line;
    end
    exp_busy = m_active || m_wait;
  end

  // ---------------------------------------------------------------------------
  // Bookkeeping and comparison helpers.
  // ---------------------------------------------------------------------------
  int         errors, checks;
  bit         stim_done;
  logic [7:0] rx_q[$];
  int         fe_cnt, ovr_cnt, rises, valid_hi, rise_cyc, last_start;
  logic       prev_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic line_hold(input logic val, input int n);
    rx_line = val;
    repeat (n) @(negedge clk);
  endtask

  // Drives one 8N1 character starting at a negedge; stop_low > 0 holds the stop
  // bit low for that many cycles before releasing the line.
  task automatic send_frame(input logic [7:0] b, input int stop_low);
    logic [7:0] sh;
    sh         = b;
    last_start = cyc;
    line_hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) begin
      line_hold(sh[0], CPB);
      sh = sh >> 1;
    end
    if (stop_low > 0) line_hold(1'b0, stop_low);
    line_hold(1'b1, CPB);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"}, 32'(data), 32'h0);
    chk({tag, "_valid"}, 32'(data_valid), 32'h0);
    chk({tag, "_frame_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_overrun"}, 32'(overrun), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
  endtask

  task automatic chk_last_rx(input string tag, input logic [7:0] exp);
    if (rx_q.size() == 0) chk({tag, "_present"}, 32'h0, 32'h1);
    else chk(tag, 32'(rx_q[rx_q.size()-1]), 32'(exp));
  endtask

  int         n0, r0, f0, o0, v0;
  bit         rnd_done;

  initial begin
    rst_n      = 1'b0;
    rx_line    = 1'b1;
    data_ready = 1'b1;
    prev_valid = 1'b0;
    fork
      // Per-cycle compare against the model, plus event logging.
      begin : compare
        while (!stim_done) begin
          @(posedge clk);
          #8;
          if (m_live) begin
            chk("valid", 32'(data_valid), 32'(exp_valid));
            chk("frame_err", 32'(frame_err), 32'(exp_fe));
            chk("overrun", 32'(overrun), 32'(exp_ovr));
            chk("busy", 32'(busy), 32'(exp_busy));
            if (exp_valid === 1'b1) chk("data", 32'(data), 32'(exp_data));
          end
          if (data_valid === 1'b1 && data_ready === 1'b1) rx_q.push_back(data);
          if (frame_err === 1'b1) fe_cnt++;
          if (overrun === 1'b1) ovr_cnt++;
          if (data_valid === 1'b1 && prev_valid !== 1'b1) begin
            rises++;
            rise_cyc = cyc;
          end
          if (data_valid === 1'b1) valid_hi++;
          prev_valid = data_valid;
        end
      end

      begin : stimulus
        @(posedge clk);
        #8;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        line_hold(1'b1, 20);

        // 0xA5 with ready high: single-cycle valid at T0+953.
        r0 = rises; v0 = valid_hi; n0 = rx_q.size();
        send_frame(8'hA5, 0);
        line_hold(1'b1, 200);
        chk("a5_rises", 32'(rises - r0), 32'd1);
        chk("a5_latency", 32'(rise_cyc - last_start), 32'd953);
        chk("a5_valid_cycles", 32'(valid_hi - v0), 32'd1);
        chk("a5_count", 32'(rx_q.size() - n0), 32'd1);
        chk_last_rx("a5_data", 8'hA5);

        // Back-to-back frames with no idle gap.
        n0 = rx_q.size(); f0 = fe_cnt; o0 = ovr_cnt;
        send_frame(8'h3C, 0);
        send_frame(8'h00, 0);
        send_frame(8'hFF, 0);
        line_hold(1'b1, 200);
        chk("b2b_count", 32'(rx_q.size() - n0), 32'd3);
        if (rx_q.size() >= n0 + 3) begin
          chk("b2b_byte0", 32'(rx_q[n0]), 32'h3C);
          chk("b2b_byte1", 32'(rx_q[n0+1]), 32'h00);
          chk("b2b_byte2", 32'(rx_q[n0+2]), 32'hFF);
        end
        chk("b2b_no_fe", 32'(fe_cnt - f0), 32'd0);
        chk("b2b_no_ovr", 32'(ovr_cnt - o0), 32'd0);

        // Stop bit held low for 1.5 bit times, then a clean byte.
        r0 = rises; f0 = fe_cnt;
        send_frame(8'h55, 150);
        line_hold(1'b1, 300);
        chk("fe_pulses", 32'(fe_cnt - f0), 32'd1);
        chk("fe_no_valid", 32'(rises - r0), 32'd0);
        send_frame(8'h12, 0);
        line_hold(1'b1, 200);
        chk_last_rx("fe_recover", 8'h12);

        // 30-cycle glitch: false start, nothing reported.
        r0 = rises; f0 = fe_cnt; o0 = ovr_cnt;
        line_hold(1'b0, 30);
        chk("glitch_busy", 32'(busy), 32'd1);
        line_hold(1'b1, 100);
        chk("glitch_idle", 32'(busy), 32'd0);
        chk("glitch_no_valid", 32'(rises - r0), 32'd0);
        chk("glitch_no_pulse", 32'((fe_cnt - f0) + (ovr_cnt - o0)), 32'd0);

        // Overrun: consumer stalled across two bytes.
        data_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 0);
        line_hold(1'b1, 50);
        send_frame(8'h22, 0);
        line_hold(1'b1, 200);
        chk("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        chk("ovr_data", 32'(data), 32'h11);
        data_ready = 1'b1;
        @(negedge clk);
        data_ready = 1'b0;
        line_hold(1'b1, 3);
        chk("ovr_drained", 32'(data_valid), 32'd0);
        chk_last_rx("ovr_accepted", 8'h11);
        data_ready = 1'b1;
        line_hold(1'b1, 20);

        // One-cycle reset in the middle of data bit 4 of 0x81.
        r0 = rises;
        fork
          send_frame(8'h81, 0);
          begin
            repeat (5 * CPB + HALF) @(negedge clk);
            rst_n = 1'b0;
            @(posedge clk);
            #8;
            chk_reset_outputs("midrst");
            @(negedge clk);
            rst_n = 1'b1;
          end
        join
        chk("midrst_no_byte", 32'(rises - r0), 32'd0);
        line_hold(1'b1, 1200);
        send_frame(8'h7E, 0);
        line_hold(1'b1, 200);
        chk_last_rx("midrst_recover", 8'h7E);

        // Randomized traffic, stalls, errors, glitches and resets.
        rnd_done = 1'b0;
        fork
          begin
            for (int it = 0; it < 30; it++) begin
              int kind;
              kind = $urandom_range(0, 19);
              if (kind < 14) begin
                send_frame(8'($urandom), 0);
                line_hold(1'b1, $urandom_range(0, 150));
              end else if (kind < 16) begin
                send_frame(8'($urandom), $urandom_range(60, 250));
                line_hold(1'b1, $urandom_range(0, 150));
              end else if (kind < 18) begin
                line_hold(1'b0, $urandom_range(1, 45));
                line_hold(1'b1, $urandom_range(5, 60));
              end else begin
                fork
                  send_frame(8'($urandom), 0);
                  begin
                    repeat ($urandom_range(1, 999)) @(negedge clk);
                    rst_n = 1'b0;
                    @(negedge clk);
                    rst_n = 1'b1;
                  end
                join
                line_hold(1'b1, 700);
              end
            end
            rnd_done = 1'b1;
          end
          begin
            while (!rnd_done) begin
              data_ready = ($urandom_range(0, 3) != 0);
              repeat ($urandom_range(1, 1500)) @(negedge clk);
            end
          end
        join
        data_ready = 1'b1;
        line_hold(1'b1, 300);
        stim_done = 1'b1;
      end
    join
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
